// File: rtl/tc_phase_sequencer_pkg.sv
// Shared phase codes, lamp encodings and phase-duration helpers for the traffic phase sequencer.
package tc_pkg;

    localparam logic [2:0] PH_AR_A = 3'd0;
    localparam logic [2:0] PH_NS_G = 3'd1;
    localparam logic [2:0] PH_NS_Y = 3'd2;
    localparam logic [2:0] PH_AR_B = 3'd3;
    localparam logic [2:0] PH_EW_G = 3'd4;
    localparam logic [2:0] PH_EW_Y = 3'd5;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
    } lamps_t;

    function automatic int phase_dur(input logic [2:0] p, input int g_ns, input int g_ew,
                                     input int yel, input int ar);
        int d;
        case (p)
            PH_NS_G:          d = g_ns;
            PH_EW_G:          d = g_ew;
            PH_NS_Y, PH_EW_Y: d = yel;
            default:          d = ar;
        endcase
        return d;
    endfunction

    function automatic logic [2:0] next_phase(input logic [2:0] p);
        return (p == PH_EW_Y) ? PH_AR_A : p + 3'd1;
    endfunction

    // Unused/illegal codes fall back to all-red so the lamps can never go dark.
    function automatic lamps_t phase_lamps(input logic [2:0] p);
        lamps_t l;
        l.ns = RED;
        l.ew = RED;
        case (p)
            PH_NS_G: l.ns = GRN;
            PH_NS_Y: l.ns = YEL;
            PH_EW_G: l.ew = GRN;
            PH_EW_Y: l.ew = YEL;
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tc_phase_sequencer_if.sv
// Control/status bundle between the intersection I/O and the phase sequencer.
interface tc_phase_sequencer_if #(
    parameter int TW = 8
);
    logic          enable;
    logic          ped_req;
    logic          emerg;
    logic [2:0]    ns_light;
    logic [2:0]    ew_light;
    logic [2:0]    phase;
    logic [TW-1:0] time_left;
    logic          ped_grant;

    modport master (
        output enable, ped_req, emerg,
        input  ns_light, ew_light, phase, time_left, ped_grant
    );

    modport slave (
        input  enable, ped_req, emerg,
        output ns_light, ew_light, phase, time_left, ped_grant
    );
endinterface

// File: rtl/tc_phase_sequencer_tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV clocks while enabled; frozen (no tick) when disabled.
module tc_tick_gen #(
    parameter int TICK_DIV = 40000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    output logic o_tick
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] r_pre;
    logic          w_wrap;

    assign w_wrap = (r_pre == PW'(TICK_DIV - 1));
    assign o_tick = i_enable & w_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
        end else if (i_enable) begin
            r_pre <= w_wrap ? '0 : r_pre + PW'(1);
        end
    end
endmodule

// File: rtl/tc_phase_sequencer.sv
// Two-road phase FSM with ped early-end and emergency all-red hold; all outputs registered,
// so lamps/phase change on the clock edge that ends a phase.
module tc_phase_sequencer
    import tc_pkg::*;
#(
    parameter int TICK_DIV  = 40000000,
    parameter int TW        = 8,
    parameter int GREEN_NS  = 30,
    parameter int GREEN_EW  = 20,
    parameter int YELLOW    = 4,
    parameter int ALL_RED   = 2,
    parameter int MIN_GREEN = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    tc_phase_sequencer_if.slave  bus
);

    logic          w_tick;
    logic [2:0]    r_phase;
    logic [TW-1:0] r_cnt;
    logic          r_ped_pend;
    logic          r_ped_grant;
    lamps_t        r_lamps;
    logic [TW-1:0] r_time_left;

    logic [TW-1:0] w_dur;
    logic          w_green;
    logic          w_allred;
    logic          w_last;
    logic          w_min_ok;
    logic [2:0]    w_nxt_phase;
    logic [TW-1:0] w_nxt_cnt;
    logic [TW-1:0] w_nxt_tl;
    logic          w_grant;

    tc_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .i_enable (bus.enable),
        .o_tick   (w_tick)
    );

    assign w_dur    = TW'(phase_dur(r_phase, GREEN_NS, GREEN_EW, YELLOW, ALL_RED));
    assign w_green  = (r_phase == PH_NS_G) || (r_phase == PH_EW_G);
    assign w_allred = (r_phase == PH_AR_A) || (r_phase == PH_AR_B);
    assign w_last   = (r_cnt == w_dur - TW'(1));
    assign w_min_ok = (r_cnt >= TW'(MIN_GREEN - 1));

    // Emergency abort needs no tick and is checked first; a ped request is not
    // served by an emergency abort, only by a normal green->yellow step.
    always_comb begin
        w_nxt_phase = r_phase;
        w_nxt_cnt   = r_cnt;
        w_grant     = 1'b0;
        if (bus.emerg && w_green) begin
            w_nxt_phase = next_phase(r_phase);
            w_nxt_cnt   = '0;
        end else if (bus.emerg && w_allred) begin
            w_nxt_cnt   = '0;
        end else if (w_tick) begin
            if (w_last || (w_green && r_ped_pend && w_min_ok)) begin
                w_nxt_phase = next_phase(r_phase);
                w_nxt_cnt   = '0;
                w_grant     = w_green && r_ped_pend;
            end else begin
                w_nxt_cnt   = r_cnt + TW'(1);
            end
        end
    end

    assign w_nxt_tl = TW'(phase_dur(w_nxt_phase, GREEN_NS, GREEN_EW, YELLOW, ALL_RED))
                      - TW'(1) - w_nxt_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase     <= PH_AR_A;
            r_cnt       <= '0;
            r_ped_pend  <= 1'b0;
            r_ped_grant <= 1'b0;
            r_lamps     <= '{ns: RED, ew: RED};
            r_time_left <= TW'(ALL_RED - 1);
        end else begin
            r_phase     <= w_nxt_phase;
            r_cnt       <= w_nxt_cnt;
            r_ped_pend  <= bus.ped_req | (r_ped_pend & ~w_grant);
            r_ped_grant <= w_grant;
            r_lamps     <= phase_lamps(w_nxt_phase);
            r_time_left <= w_nxt_tl;
        end
    end

    assign bus.phase     = r_phase;
    assign bus.ns_light  = r_lamps.ns;
    assign bus.ew_light  = r_lamps.ew;
    assign bus.time_left = r_time_left;
    assign bus.ped_grant = r_ped_grant;

endmodule

// File: tb/tb_tc_phase_sequencer.sv
// Directed + randomized bench for tc_phase_sequencer against a rule-level reference model.
module tb_tc_phase_sequencer;
    localparam int TD = 4, GNS = 6, GEW = 5, YEL = 2, AR = 2, MG = 3, TW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tc_phase_sequencer_if #(.TW(TW)) bus ();

    tc_phase_sequencer #(
        .TICK_DIV (TD), .TW (TW), .GREEN_NS (GNS), .GREEN_EW (GEW),
        .YELLOW (YEL), .ALL_RED (AR), .MIN_GREEN (MG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // Reference model: seconds-level view of the intersection.
    int dur [6] = '{AR, GNS, YEL, AR, GEW, YEL};
    int m_clk_in_tick, m_phase, m_ticks_in_phase;
    bit m_pend, m_grant;

    function automatic logic [2:0] exp_ns(int p);
        if (p == 1) return 3'b001;
        if (p == 2) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [2:0] exp_ew(int p);
        if (p == 4) return 3'b001;
        if (p == 5) return 3'b010;
        return 3'b100;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_clk_in_tick = 0; m_phase = 0; m_ticks_in_phase = 0; m_pend = 0; m_grant = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit tick, green, allred, clr;
        tick   = bus.enable && (m_clk_in_tick == TD - 1);
        green  = (m_phase == 1) || (m_phase == 4);
        allred = (m_phase == 0) || (m_phase == 3);
        clr    = 0;
        m_grant = 0;
        if (bus.enable) m_clk_in_tick = (m_clk_in_tick + 1) % TD;
        if (bus.emerg && green) begin
            m_phase = (m_phase + 1) % 6; m_ticks_in_phase = 0;
        end else if (bus.emerg && allred) begin
            m_ticks_in_phase = 0;
        end else if (tick) begin
            if (m_ticks_in_phase + 1 >= dur[m_phase] ||
                (green && m_pend && m_ticks_in_phase + 1 >= MG)) begin
                if (green && m_pend) begin m_grant = 1; clr = 1; end
                m_phase = (m_phase + 1) % 6; m_ticks_in_phase = 0;
            end else begin
                m_ticks_in_phase++;
            end
        end
        m_pend = bus.ped_req ? 1'b1 : (clr ? 1'b0 : m_pend);
    endtask

    task automatic check_outputs(string tag);
        check({tag, "_phase"}, 32'(bus.phase), 32'(m_phase));
        check({tag, "_ns"}, 32'(bus.ns_light), 32'(exp_ns(m_phase)));
        check({tag, "_ew"}, 32'(bus.ew_light), 32'(exp_ew(m_phase)));
        check({tag, "_tleft"}, 32'(bus.time_left), 32'(dur[m_phase] - 1 - m_ticks_in_phase));
        check({tag, "_grant"}, 32'(bus.ped_grant), 32'(m_grant));
        check({tag, "_bothgo"}, 32'(bus.ns_light != 3'b100 && bus.ew_light != 3'b100), 32'd0);
    endtask

    task automatic step(string tag);
        model_step();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic run(int n, string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic wait_for(int p, int c, int budget, string tag);
        int found = 0;
        for (int k = 0; k < budget && found == 0; k++) begin
            if (m_phase == p && m_ticks_in_phase == c) found = 1;
            else step(tag);
        end
        check({tag, "_reached"}, 32'(found), 32'd1);
    endtask

    initial begin
        int edges [$];
        int exp_edges [6] = '{8, 32, 40, 48, 68, 76};
        logic [2:0] prev;
        int grants;
        logic [2:0] fz_phase;
        logic [TW-1:0] fz_tl;

        bus.enable = 1'b0; bus.ped_req = 1'b0; bus.emerg = 1'b0;
        #12;
        check("rst_phase", 32'(bus.phase), 32'd0);
        check("rst_ns", 32'(bus.ns_light), 32'h4);
        check("rst_ew", 32'(bus.ew_light), 32'h4);
        check("rst_tleft", 32'(bus.time_left), 32'(AR - 1));
        check("rst_grant", 32'(bus.ped_grant), 32'd0);
        rst = 1'b0;
        model_reset();
        bus.enable = 1'b1;

        // Free-running cycle: phase boundaries at fixed clock counts.
        prev = bus.phase;
        for (int i = 1; i <= 80; i++) begin
            step("cycle");
            if (bus.phase !== prev) edges.push_back(i);
            prev = bus.phase;
        end
        for (int i = 0; i < 6; i++)
            check($sformatf("edge%0d", i), 32'(i < edges.size() ? edges[i] : -1), 32'(exp_edges[i]));

        // Ped pulse at first NS_G tick count: green cut to MIN_GREEN, one grant.
        wait_for(1, 0, 200, "w_nsg0");
        bus.ped_req = 1'b1; step("ped0"); bus.ped_req = 1'b0;
        grants = 0;
        for (int i = 0; i < 40; i++) begin
            step("ped0");
            if (bus.ped_grant === 1'b1) grants++;
        end
        check("ped0_grants", 32'(grants), 32'd1);

        // Ped late in NS_G, then one during AR_B served in EW_G.
        wait_for(1, 4, 200, "w_nsg4");
        bus.ped_req = 1'b1; step("ped4"); bus.ped_req = 1'b0;
        wait_for(3, 0, 200, "w_arb");
        bus.ped_req = 1'b1; step("pedarb"); bus.ped_req = 1'b0;
        run(60, "pedarb");

        // Emergency during EW_G, held through AR_A, then released.
        wait_for(4, 2, 200, "w_ewg");
        bus.emerg = 1'b1;
        step("emg");
        check("emg_abort", 32'(bus.phase), 32'd5);
        run(30, "emg");
        check("emg_hold", 32'(bus.phase), 32'd0);
        bus.emerg = 1'b0;
        run(40, "emg_rel");

        // Freeze mid NS_Y.
        wait_for(2, 0, 200, "w_nsy");
        step("frz");
        bus.enable = 1'b0;
        fz_phase = bus.phase; fz_tl = bus.time_left;
        run(50, "frz");
        check("frz_phase", 32'(bus.phase), 32'(fz_phase));
        check("frz_tleft", 32'(bus.time_left), 32'(fz_tl));
        bus.enable = 1'b1;
        run(30, "frz_res");

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            bus.ped_req = ($urandom_range(7) == 0);
            if ($urandom_range(29) == 0) bus.emerg = ~bus.emerg;
            bus.enable = ($urandom_range(9) != 0);
            step("rnd");
        end
        bus.ped_req = 1'b0; bus.emerg = 1'b0; bus.enable = 1'b1;

        // Async reset mid EW_Y.
        wait_for(5, 0, 300, "w_ewy");
        step("ewy");
        #3;
        rst = 1'b1;
        #1;
        check("arst_ns", 32'(bus.ns_light), 32'h4);
        check("arst_ew", 32'(bus.ew_light), 32'h4);
        check("arst_phase", 32'(bus.phase), 32'd0);
        check("arst_tleft", 32'(bus.time_left), 32'(AR - 1));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs("arst_hold");
        run(20, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
